// File: rtl/axis_hdr_pkg.sv
// ---------------------------------------------------------------------------
// axis_hdr_pkg
// Shared types and helpers for the AXI-Stream header-insert arbitration path.
//   hdr_state_e : arbiter FSM state encoding (2-bit)
//   rr_pick_t   : result of a round-robin pick (one-hot, index, any-valid)
//   rr_pick()   : combinational round-robin search starting after ptr
// Supports up to RR_MAX_REQ requesters.
// ---------------------------------------------------------------------------
package axis_hdr_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        OFFER    = 2'd1,
        WAIT_EOP = 2'd2
    } hdr_state_e;

    localparam int RR_MAX_REQ = 32;
    localparam int RR_IDX_WD  = 5;

    typedef struct packed {
        logic                  any;
        logic [RR_IDX_WD-1:0]  idx;
        logic [RR_MAX_REQ-1:0] onehot;
    } rr_pick_t;

    // Searches (ptr+1) mod num_req upward with wrap. The loop runs from the
    // farthest candidate to the nearest so the nearest valid one is written
    // last and wins, which avoids an early exit in hardware.
    function automatic rr_pick_t rr_pick(input logic [RR_MAX_REQ-1:0] req,
                                         input int ptr,
                                         input int num_req);
        rr_pick_t r;
        int       c;
        r = '0;
        for (int k = RR_MAX_REQ; k > 0; k--) begin
            if (k <= num_req) begin
                c = ptr + k;
                if (c >= num_req) begin
                    c = c - num_req;
                end
                if (req[c[RR_IDX_WD-1:0]]) begin
                    r.any = 1'b1;
                    r.idx = c[RR_IDX_WD-1:0];
                end
            end
        end
        if (r.any) begin
            r.onehot[r.idx] = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/axis_header_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter: combinational one-hot pick plus registered pointer
// holding the last granted index. The requester just served gets the lowest
// priority on the next pick.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset (pointer -> NUM_REQ-1)
//   req         : request vector
//   grant_en    : when high and a request is present, pointer moves to pick
//   grant       : one-hot pick (zero when no request)
//   grant_idx   : index of the pick
//   grant_any   : at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_WD   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               grant_en,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_WD-1:0]   grant_idx,
    output logic               grant_any
);
    import axis_hdr_pkg::*;

    logic [ID_WD-1:0] rr_ptr;
    rr_pick_t         pick;
    logic             unused_pick;

    always_comb begin
        pick = rr_pick(RR_MAX_REQ'(req), int'(rr_ptr), NUM_REQ);
    end

    assign grant       = pick.onehot[NUM_REQ-1:0];
    assign grant_idx   = pick.idx[ID_WD-1:0];
    assign grant_any   = pick.any;
    // Upper bits of the generic pick are always zero for this instance.
    assign unused_pick = ^pick;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr <= ID_WD'(NUM_REQ - 1);
        end else if (grant_en && pick.any) begin
            rr_ptr <= grant_idx;
        end
    end

endmodule

// File: rtl/axis_header_arbiter.sv
// ---------------------------------------------------------------------------
// axis_header_arbiter
// Round-robin scheduler binding exactly one header to each output packet.
// A header is taken from one of NUM_REQ sources, offered to the insert block,
// and the next grant is held off until last_out is accepted on the stream.
//
// State table:
//   IDLE     | pick a requester, pulse its req_ready, latch its header
//   OFFER    | valid_insert high with latched header until ready_insert
//   WAIT_EOP | watch output stream for valid&ready&last, then back to IDLE
//
// Ports:
//   clk, rst_n                      : clock, synchronous active-low reset
//   req_valid/data/keep/byte_cnt    : packed per-requester header inputs
//   req_ready                       : one-hot accept pulse (combinational)
//   valid_insert/data_insert/
//   keep_insert/byte_insert_cnt     : registered header channel to insert blk
//   ready_insert                    : insert block accepts header
//   valid_out/ready_out/last_out    : monitored output stream handshake
//   grant_id                        : index of current owner (registered)
//   timeout_err                     : one-cycle watchdog pulse (optional)
//   busy                            : state != IDLE
//
// Build option: define HDR_ARB_TIMEOUT_EN to add the WAIT_EOP watchdog and
// the timeout_err port. Without it WAIT_EOP waits indefinitely.
// ---------------------------------------------------------------------------
module axis_header_arbiter #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
    parameter int NUM_REQ      = 4,
    parameter int REQ_ID_WD    = $clog2(NUM_REQ),
    parameter int TIMEOUT_CYC  = 1024
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*DATA_WD-1:0]      req_data,
    input  logic [NUM_REQ*DATA_BYTE_WD-1:0] req_keep,
    input  logic [NUM_REQ*BYTE_CNT_WD-1:0]  req_byte_cnt,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic                            valid_insert,
    output logic [DATA_WD-1:0]              data_insert,
    output logic [DATA_BYTE_WD-1:0]         keep_insert,
    output logic [BYTE_CNT_WD-1:0]          byte_insert_cnt,
    input  logic                            ready_insert,
    input  logic                            valid_out,
    input  logic                            ready_out,
    input  logic                            last_out,
    output logic [REQ_ID_WD-1:0]            grant_id,
`ifdef HDR_ARB_TIMEOUT_EN
    output logic                            timeout_err,
`endif
    output logic                            busy
);
    import axis_hdr_pkg::*;

    hdr_state_e           state;
    logic [NUM_REQ-1:0]   grant;
    logic [REQ_ID_WD-1:0] grant_idx;
    logic                 grant_any;
    logic                 arb_en;
    logic                 eop;

    // Arbitration only in IDLE; gated by reset so no source sees an accept
    // that the held-in-reset FSM would not act on.
    assign arb_en    = (state == IDLE) && rst_n;
    assign req_ready = arb_en ? grant : '0;
    assign eop       = valid_out && ready_out && last_out;
    assign busy      = (state != IDLE);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_WD   (REQ_ID_WD)
    ) u_rr_arbiter (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req_valid),
        .grant_en  (arb_en),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

`ifdef HDR_ARB_TIMEOUT_EN
    localparam int TO_WD = $clog2(TIMEOUT_CYC + 1);
    logic [TO_WD-1:0] to_cnt;
    logic             to_hit;
    // Leaving on the cycle the count would reach TIMEOUT_CYC.
    assign to_hit = (to_cnt == TO_WD'(TIMEOUT_CYC - 1));
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYC;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            valid_insert    <= 1'b0;
            data_insert     <= '0;
            keep_insert     <= '0;
            byte_insert_cnt <= '0;
            grant_id        <= '0;
`ifdef HDR_ARB_TIMEOUT_EN
            to_cnt          <= '0;
            timeout_err     <= 1'b0;
`endif
        end else begin
`ifdef HDR_ARB_TIMEOUT_EN
            timeout_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        data_insert     <= req_data[grant_idx*DATA_WD +: DATA_WD];
                        keep_insert     <= req_keep[grant_idx*DATA_BYTE_WD +: DATA_BYTE_WD];
                        byte_insert_cnt <= req_byte_cnt[grant_idx*BYTE_CNT_WD +: BYTE_CNT_WD];
                        grant_id        <= grant_idx;
                        valid_insert    <= 1'b1;
                        state           <= OFFER;
                    end
                end
                OFFER: begin
                    if (ready_insert) begin
                        valid_insert <= 1'b0;
                        state        <= WAIT_EOP;
`ifdef HDR_ARB_TIMEOUT_EN
                        to_cnt       <= '0;
`endif
                    end
                end
                WAIT_EOP: begin
                    if (eop) begin
                        state <= IDLE;
`ifdef HDR_ARB_TIMEOUT_EN
                    end else if (to_hit) begin
                        state       <= IDLE;
                        timeout_err <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
`endif
                    end
                end
                default: begin
                    state        <= IDLE;
                    valid_insert <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_header_arbiter.sv
module tb_axis_header_arbiter;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int CW = 2;
    localparam int NR = 4;
    localparam int IW = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NR-1:0]    req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR*BW-1:0] req_keep;
    logic [NR*CW-1:0] req_byte_cnt;
    logic [NR-1:0]    req_ready;
    logic             valid_insert;
    logic [DW-1:0]    data_insert;
    logic [BW-1:0]    keep_insert;
    logic [CW-1:0]    byte_insert_cnt;
    logic             ready_insert;
    logic             valid_out;
    logic             ready_out;
    logic             last_out;
    logic [IW-1:0]    grant_id;
    logic             busy;
`ifdef HDR_ARB_TIMEOUT_EN
    logic             timeout_err;
`endif

    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0] hdr   [NR];
    logic [BW-1:0] keeps [NR];
    logic [CW-1:0] cnts  [NR];

    always #5 clk = ~clk;

    axis_header_arbiter #(
        .DATA_WD     (DW),
        .NUM_REQ     (NR),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_data        (req_data),
        .req_keep        (req_keep),
        .req_byte_cnt    (req_byte_cnt),
        .req_ready       (req_ready),
        .valid_insert    (valid_insert),
        .data_insert     (data_insert),
        .keep_insert     (keep_insert),
        .byte_insert_cnt (byte_insert_cnt),
        .ready_insert    (ready_insert),
        .valid_out       (valid_out),
        .ready_out       (ready_out),
        .last_out        (last_out),
        .grant_id        (grant_id),
`ifdef HDR_ARB_TIMEOUT_EN
        .timeout_err     (timeout_err),
`endif
        .busy            (busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // One full packet: IDLE grant, one OFFER cycle (ready_insert high),
    // then nbeats stream beats with last on the final one. Ends at the
    // negedge of the following (IDLE) cycle.
    task automatic packet(input int id, input int nbeats);
        #1;
        chk("idle_rdy", 64'(req_ready), 64'(1) << id);
        chk("idle_busy", 64'(busy), 64'(0));
        step();
        #1;
        chk("offer_vld", 64'(valid_insert), 64'(1));
        chk("offer_data", 64'(data_insert), 64'(hdr[id]));
        chk("offer_keep", 64'(keep_insert), 64'(keeps[id]));
        chk("offer_cnt", 64'(byte_insert_cnt), 64'(cnts[id]));
        chk("offer_gid", 64'(grant_id), 64'(id));
        chk("offer_rdy", 64'(req_ready), 64'(0));
        step();
        for (int b = 0; b < nbeats; b++) begin
            valid_out = 1'b1;
            ready_out = 1'b1;
            last_out  = (b == nbeats - 1);
            #1;
            chk("wait_vld", 64'(valid_insert), 64'(0));
            chk("wait_busy", 64'(busy), 64'(1));
            chk("wait_rdy", 64'(req_ready), 64'(0));
            step();
        end
        valid_out = 1'b0;
        last_out  = 1'b0;
    endtask

    initial begin
        hdr   = '{32'hA1B2C3D4, 32'h11223344, 32'h55667788, 32'h99AABBCC};
        keeps = '{4'hF, 4'h7, 4'h3, 4'h1};
        cnts  = '{2'd1, 2'd3, 2'd2, 2'd0};
        for (int i = 0; i < NR; i++) begin
            req_data[i*DW +: DW]     = hdr[i];
            req_keep[i*BW +: BW]     = keeps[i];
            req_byte_cnt[i*CW +: CW] = cnts[i];
        end
        rst_n        = 1'b0;
        req_valid    = '1;
        ready_insert = 1'b1;
        valid_out    = 1'b0;
        ready_out    = 1'b0;
        last_out     = 1'b0;

        // Reset state, with all requesters valid during reset
        step();
        step();
        #1;
        chk("rst_vld", 64'(valid_insert), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_gid", 64'(grant_id), 64'(0));
        chk("rst_data", 64'(data_insert), 64'(0));
        chk("rst_rdy", 64'(req_ready), 64'(0));

        // Single requester, back-to-back 3-beat packets
        rst_n     = 1'b1;
        req_valid = 4'b0001;
        for (int p = 0; p < 3; p++) packet(0, 3);

        // No requesters: stay idle
        req_valid = 4'b0000;
        #1;
        chk("none_rdy", 64'(req_ready), 64'(0));
        step();
        #1;
        chk("none_busy", 64'(busy), 64'(0));

        // All valid from reset: 0,1,2,3,0,1
        rst_n = 1'b0;
        step();
        rst_n     = 1'b1;
        req_valid = 4'b1111;
        packet(0, 2);
        packet(1, 2);
        packet(2, 2);
        packet(3, 2);
        packet(0, 2);
        packet(1, 2);

        // OFFER stall with stream last beats that must be ignored
        #1;
        chk("stall_grant", 64'(req_ready), 64'(4'b0100));
        step();
        ready_insert = 1'b0;
        valid_out    = 1'b1;
        ready_out    = 1'b1;
        last_out     = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("stall_vld", 64'(valid_insert), 64'(1));
            chk("stall_data", 64'(data_insert), 64'(hdr[2]));
            chk("stall_gid", 64'(grant_id), 64'(2));
            chk("stall_rdy", 64'(req_ready), 64'(0));
            step();
        end
        valid_out    = 1'b0;
        last_out     = 1'b0;
        ready_insert = 1'b1;
        step();
        #1;
        chk("hs_vld", 64'(valid_insert), 64'(0));
        chk("hs_busy", 64'(busy), 64'(1));

        // last without handshake for 3 cycles, then handshake
        valid_out = 1'b1;
        last_out  = 1'b1;
        ready_out = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("nohs_busy", 64'(busy), 64'(1));
            chk("nohs_rdy", 64'(req_ready), 64'(0));
            step();
        end
        ready_out = 1'b1;
        #1;
        chk("eop_rdy", 64'(req_ready), 64'(0));
        step();
        valid_out = 1'b0;
        last_out  = 1'b0;
        #1;
        chk("post_busy", 64'(busy), 64'(0));
        chk("post_rdy", 64'(req_ready), 64'(4'b1000));
        step();
        #1;
        chk("g3_vld", 64'(valid_insert), 64'(1));
        chk("g3_gid", 64'(grant_id), 64'(3));

        // Reset while offering
        rst_n = 1'b0;
        step();
        #1;
        chk("mrst_vld", 64'(valid_insert), 64'(0));
        chk("mrst_busy", 64'(busy), 64'(0));
        chk("mrst_gid", 64'(grant_id), 64'(0));
        chk("mrst_rdy", 64'(req_ready), 64'(0));
        rst_n = 1'b1;
        packet(0, 1);

        // Lone requester and requesters dropping out
        req_valid = 4'b0100;
        packet(2, 1);
        packet(2, 2);
        req_valid = 4'b1010;
        packet(3, 1);
        req_valid = 4'b0010;
        packet(1, 1);

`ifdef HDR_ARB_TIMEOUT_EN
        rst_n     = 1'b0;
        req_valid = 4'b0000;
        step();
        rst_n     = 1'b1;
        req_valid = 4'b0010;
        #1;
        chk("to_grant", 64'(req_ready), 64'(4'b0010));
        step();
        #1;
        chk("to_vld", 64'(valid_insert), 64'(1));
        step();
        req_valid = 4'b0000;
        for (int k = 1; k <= 16; k++) begin
            #1;
            chk("to_wait_err", 64'(timeout_err), 64'(0));
            chk("to_wait_busy", 64'(busy), 64'(1));
            step();
        end
        #1;
        chk("to_err", 64'(timeout_err), 64'(1));
        chk("to_busy", 64'(busy), 64'(0));
        req_valid = 4'b1111;
        #1;
        chk("to_next", 64'(req_ready), 64'(4'b0100));
        step();
        #1;
        chk("to_err_clr", 64'(timeout_err), 64'(0));
        chk("to_gid", 64'(grant_id), 64'(2));
        step();
        for (int k = 1; k <= 15; k++) begin
            #1;
            chk("to2_busy", 64'(busy), 64'(1));
            step();
        end
        valid_out = 1'b1;
        ready_out = 1'b1;
        last_out  = 1'b1;
        #1;
        chk("to2_eop_busy", 64'(busy), 64'(1));
        step();
        valid_out = 1'b0;
        last_out  = 1'b0;
        #1;
        chk("to2_busy_end", 64'(busy), 64'(0));
        chk("to2_err", 64'(timeout_err), 64'(0));
        step();
        #1;
        chk("to2_err_late", 64'(timeout_err), 64'(0));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/axis_header_arbiter.md
Name: axis_header_arbiter

Overview:
- Schedules header insertion for the AXI-Stream header-insert datapath.
- Arbitrates round-robin among NUM_REQ header sources.
- Presents one header at a time on the insert block's header channel (valid_insert/data_insert/keep_insert/byte_insert_cnt/ready_insert).
- Holds off the next grant until the end of the current packet (last_out accepted on the output stream), so exactly one header is bound to each packet.

Parameters:
- DATA_WD, 32, header data width.
- DATA_BYTE_WD, DATA_WD/8, keep width.
- BYTE_CNT_WD, $clog2(DATA_BYTE_WD), byte_insert_cnt width.
- NUM_REQ, 4, number of header requesters (>=2).
- REQ_ID_WD, $clog2(NUM_REQ), grant index width.
- TIMEOUT_CYC, 1024, watchdog limit (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester header valid.
- req_data  in  NUM_REQ*DATA_WD  packed headers; requester i at [i*DATA_WD +: DATA_WD].
- req_keep  in  NUM_REQ*DATA_BYTE_WD  packed keeps.
- req_byte_cnt  in  NUM_REQ*BYTE_CNT_WD  packed byte counts.
- req_ready  out  NUM_REQ  one-hot accept pulse.
- valid_insert  out  1  header valid to the insert block.
- data_insert  out  DATA_WD  granted header.
- keep_insert  out  DATA_BYTE_WD  granted keep.
- byte_insert_cnt  out  BYTE_CNT_WD  granted byte count.
- ready_insert  in  1  insert block accepts header.
- valid_out  in  1  monitored output-stream valid.
- ready_out  in  1  monitored output-stream ready.
- last_out  in  1  monitored output-stream last.
- grant_id  out  REQ_ID_WD  index of the current owner.
- busy  out  1  high when not in IDLE.

Behaviour:
- Reset (rst_n low at a clk edge) drives all outputs to 0 and sets state to IDLE, rr_ptr to NUM_REQ-1, and the header register to 0. Applies mid-operation too: any header being offered is dropped and valid_insert is low after that edge.
- State IDLE:
  - Combinational round-robin pick: the first i with req_valid[i]=1, searching from (rr_ptr+1) mod NUM_REQ upward with wrap.
  - If any requester is valid, req_ready[i]=1 in the same cycle and the header is accepted.
  - On the next edge: req_data/keep/byte_cnt slice i is registered, grant_id<=i, rr_ptr<=i, state goes to OFFER.
  - If no requester is valid, state stays IDLE and req_ready=0.
- State OFFER:
  - valid_insert=1 with registered fields, held stable until ready_insert=1.
  - On the handshake edge, state goes to WAIT_EOP.
  - req_ready=0 throughout.
  - Output-stream beats are ignored in OFFER.
- State WAIT_EOP:
  - valid_insert=0.
  - On valid_out&ready_out&last_out, state goes to IDLE at the next edge.
  - A beat without last, or last without handshake, does nothing.
- Latency:
  - Request accepted to valid_insert high: 1 cycle.
  - EOP to next req_ready: 1 cycle. There is one mandatory IDLE cycle between packets, and no grant in the EOP cycle itself.
- Fairness:
  - The requester just served has lowest priority next round.
  - With all requesters continuously valid, grants cycle 0,1,...,NUM_REQ-1,0...
  - A lone requester is granted every packet.
- Requesters may drop req_valid while not granted; no state is held for them.
- ready_insert asserted outside OFFER is ignored.
- busy = (state != IDLE).
- Outputs valid_insert, data_insert, keep_insert, byte_insert_cnt and grant_id are registered. req_ready is combinational from IDLE, req_valid and rr_ptr.

Optional Feature:
- Macro: HDR_ARB_TIMEOUT_EN.
- When defined:
  - Adds output timeout_err (1 bit) and a $clog2(TIMEOUT_CYC+1)-bit counter.
  - The counter clears on entry to WAIT_EOP and increments each WAIT_EOP cycle without EOP.
  - When it reaches TIMEOUT_CYC: state goes to IDLE, timeout_err pulses high for 1 cycle, and rr_ptr is unchanged.
  - EOP arriving in the same cycle as the timeout wins: normal exit, no error.
- When undefined: no counter and no port; WAIT_EOP waits indefinitely.

Decomposition:
- Shared package axis_hdr_pkg:
  - State enum {IDLE, OFFER, WAIT_EOP} (2-bit).
  - Function rr_pick(req, ptr) returning the one-hot grant and its index.
- Sub-module rr_arbiter (parameter NUM_REQ): combinational one-hot round-robin pick plus the registered rr_ptr, update enabled on grant. It is reused by other stream muxes.
- The top level holds the FSM, header register and EOP monitor.

Test Plan:
1. Single requester, back-to-back packets: req_valid=0001, hdr 0xA1B2C3D4, cnt=1, ready_insert tied 1, 3-beat packets -> req_ready[0] pulses once per packet, valid_insert high 1 cycle with data 0xA1B2C3D4 and cnt 1, next req_ready exactly 1 cycle after each last handshake.
2. All four valid continuously, packets of 2 beats -> grant_id sequence 0,1,2,3,0,1; each req_ready pulse is one-hot.
3. ready_insert held 0 for 5 cycles in OFFER -> valid_insert and data stable for 5 cycles; no state change; last_out beats in this window are ignored.
4. last_out=1 with ready_out=0 in WAIT_EOP for 3 cycles, then ready_out=1 -> IDLE only after the handshake cycle.
5. Reset asserted in OFFER -> valid_insert=0, busy=0, grant_id=0 after the edge; first grant after reset with all valid goes to requester 0.
6. With HDR_ARB_TIMEOUT_EN and TIMEOUT_CYC=16, no EOP -> timeout_err pulses once after 16 WAIT_EOP cycles, then the next requester is granted. With EOP at cycle 16 -> no error.
